irq_pending_ctrl: RTL



---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_pending_ctrl_prio_enc4.sv | 21 ++
 rtl/irq_pending_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending controller.
package irq_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

  typedef logic [NREQ-1:0] irq_vec_t;

  // One-hot vector with only the bit addressed by id set.
  function automatic irq_vec_t id_onehot(input logic [ID_W-1:0] id);
    irq_vec_t oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc4.sv
// Combinational 4-to-2 priority encoder; bit 3 has the highest priority.
module prio_enc4
  import irq_pkg::*;
(
  input  logic [NREQ-1:0] vec,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan upwards so the highest set bit is the last one written and wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < NREQ; i++) begin
      if (vec[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Four-input interrupt pending controller: synchronises raw requests,
// tracks pending events, masks them and presents the highest-priority one
// through a valid/ack handshake.
// Build option: define IRQ_EDGE_CAPTURE_EN for sticky edge capture with
// ack-clear and overflow reporting; without it the controller runs in level
// mode (pend follows the synchronised request level, ovf is constant 0).
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            irq_ack,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  output logic [NREQ-1:0] pend,
  output logic            ovf
);

  localparam int SW = SYNC_STAGES * NREQ;

  logic [SW-1:0]   sync_reg;
  irq_vec_t        s;
  irq_vec_t        eligible;
  logic [ID_W-1:0] enc_idx;
  logic            enc_any;
  irq_state_t      state_reg, state_next;
  logic [ID_W-1:0] id_reg, id_next;

  // Shift raw requests through the synchroniser; newest stage at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SW-NREQ-1:0], req};
    end
  end

  assign s = sync_reg[SW-1 -: NREQ];

`ifdef IRQ_EDGE_CAPTURE_EN
  irq_vec_t s_d_reg;
  irq_vec_t pend_reg;
  logic     ovf_reg;
  irq_vec_t rise;
  irq_vec_t clr;

  assign rise = s & ~s_d_reg;
  // Clear only the presented bit, and only on an accepted ack.
  assign clr  = (state_reg == REQ && irq_ack) ? id_onehot(id_reg) : '0;

  // Sticky pending bits; a new rise overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_reg  <= '0;
      pend_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      s_d_reg  <= s;
      pend_reg <= (pend_reg & ~clr) | rise;
      ovf_reg  <= |(rise & pend_reg);
    end
  end

  assign pend = pend_reg;
  assign ovf  = ovf_reg;
`else
  // Level mode: pending simply mirrors the synchronised request level.
  assign pend = s;
  assign ovf  = 1'b0;
`endif

  assign eligible = pend & mask;

  prio_enc4 u_enc (
    .vec (eligible),
    .idx (enc_idx),
    .any (enc_any)
  );

  // FSM state and the frozen grant index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  // Grant when anything is eligible; hold the index until the ack arrives.
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (enc_any) begin
          state_next = REQ;
          id_next    = enc_idx;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign irq_valid = (state_reg == REQ);
  assign irq_id    = id_reg;

endmodule
